memory_read_arbiter_rr: RTL and testbench
=========================================

// Module: memory_read_arbiter_rr
// PURPOSE
//  Responder side of the engine memory-read interface: serves N engine-station read ports from one
//  single-port instruction memory. Round-robin grants one request per cycle, tracks in-flight reads
//  through a fixed-latency pipeline, and broadcasts read data to all ports. A one-cycle ready pulse
//  to the owning port marks the arbitration win. Sits between the engine mesh and the instruction BRAM.
// PARAMETERS
//  PORT_ID_BITS       2   N = 2**PORT_ID_BITS requesting ports
//  MEMORY_WIDTH       16  instruction word width
//  MEMORY_ADDR_WIDTH  11  word address width
//  MEM_LATENCY        1   BRAM read latency in cycles, >=1
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous, active-low reset
//  req_valid  in   N            per-port read request; held until that port's req_ready
//  req_addr   in   N*AW         per-port address, port i at [i*AW +: AW]; stable while req_valid
//  req_ready  out  N            one-cycle pulse: rsp_data belongs to this port
//  rsp_data   out  MEMORY_WIDTH broadcast read data, registered
//  mem_en     out  1            BRAM read enable
//  mem_addr   out  AW           BRAM read address
//  mem_data   in   MEMORY_WIDTH BRAM data, valid MEM_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Reset (rst==0 at posedge): req_ready=0, rsp_data=0, mem_en=0, mem_addr=0; rr pointer=N-1;
//    pending mask=0; all pipeline valid bits cleared. In-flight reads are dropped; no ready after.
//  - Eligible(i) = req_valid[i] & ~pending[i]. Each cycle with any eligible port, the grant goes to
//    the first eligible port searching ptr+1, ptr+2, ... mod N. Then ptr <= winner. No eligible port:
//    ptr is held and mem_en=0.
//  - Grant in cycle T: mem_en=1 and mem_addr=winner addr (combinational), pending[winner] set at T+1.
//    Tag {valid, owner mask} enters a MEM_LATENCY-deep shift pipeline.
//  - Response: at T+MEM_LATENCY the tag exits, and rsp_data<=mem_data and req_ready<=owner mask
//    (registered). Ready is visible in cycle T+MEM_LATENCY+1 for exactly one cycle.
//  - pending[i] clears in the cycle after its ready pulse. That is the earliest cycle port i may be
//    re-granted, with either a new address or a held valid. At most one outstanding read per port.
//  - Throughput: one grant per cycle when ports differ. Back-to-back grants pipeline, so up to
//    min(N, MEM_LATENCY+1) reads are in flight.
//  - rsp_data holds its last value when req_ready==0. Ports ignore rsp_data unless their ready bit is set.
//  - Dropped req_valid before ready is a protocol violation. The response is still delivered and
//    pending still clears normally, so no deadlock results.
//  - Simultaneous events: pending set on grant and pending clear on ready in the same cycle for
//    different ports are independent. The same port cannot be both.
//  - rst deasserted mid-traffic: arbitration restarts from ptr=N-1 (port 0 first).
// CONFIGURATION
//  MEM_ARB_COALESCE_EN defined: at grant, every other eligible port whose req_addr equals the winner
//    address joins the owner mask. All owners get req_ready in the same cycle and all set pending.
//    ptr still advances to the winner only.
//  Not defined: owner mask is one-hot (winner only). Equal addresses are served serially.
// TESTING
//  1. Reset: rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, mem_en=0 throughout. rst=1
//     -> first grant to port 0.
//  2. Single port: port 2 requests addr 0x05a, mem[0x05a]=0xBEEF, MEM_LATENCY=1 -> mem_en at T,
//     req_ready=4'b0100 at T+2, rsp_data=0xBEEF.
//  3. Fairness: all 4 ports held valid for 16 cycles -> grant order 0,1,2,3,0,1,... No port
//     granted while pending. Each port gets exactly 4 readies +-1.
//  4. Back-to-back: MEM_LATENCY=3, ports 1 and 3 request 0x010 and 0x020 -> grants at T and T+1,
//     readies at T+4 and T+5 with the matching data.
//  5. Coalesce: ports 0 and 2 both request 0x100 in the same cycle. With MEM_ARB_COALESCE_EN:
//     one mem_en, req_ready=4'b0101 together. Without: two grants, two separate pulses.
//  6. Reset mid-flight: grant at T, rst=0 at T+1 -> no req_ready ever asserted for that read.
//     Pending mask=0 after reset.

Source files
------------

// File: rtl/memory_read_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// memory_read_arbiter_rr_if
//   Bundle between the engine-station read ports, the round-robin read
//   arbiter and the single-port instruction BRAM.
//
//   Handshake: a port raises req_valid[i] with a stable req_addr slice and
//   holds both until it sees req_ready[i]. req_ready[i] is a one-cycle pulse
//   meaning "rsp_data in this same cycle is your word"; there is no
//   backpressure on the response side. A port may keep req_valid[i] high
//   after its pulse to issue another read (same or new address).
//
//   Signals
//     req_valid   [N]        per-port read request
//     req_addr    [N*AW]     per-port address, port i at [i*AW +: AW]
//     req_ready   [N]        per-port response pulse
//     rsp_data    [MW]       broadcast registered read data
//     mem_en / mem_addr      BRAM read command
//     mem_data    [MW]       BRAM read data, MEM_LATENCY cycles after mem_en
//     dbg_ptr / dbg_pending  arbiter state (round-robin pointer, busy mask)
//
//   Modports
//     slave  : the arbiter
//     master : the environment (engine ports plus BRAM)
// ---------------------------------------------------------------------------
interface memory_read_arbiter_rr_if #(
  parameter int PORT_ID_BITS      = 2,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  localparam int N = 1 << PORT_ID_BITS;

  logic [N-1:0]                   req_valid;
  logic [N*MEMORY_ADDR_WIDTH-1:0] req_addr;
  logic [N-1:0]                   req_ready;
  logic [MEMORY_WIDTH-1:0]        rsp_data;
  logic                           mem_en;
  logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr;
  logic [MEMORY_WIDTH-1:0]        mem_data;
  logic [PORT_ID_BITS-1:0]        dbg_ptr;
  logic [N-1:0]                   dbg_pending;

  modport slave (
    input  req_valid, req_addr, mem_data,
    output req_ready, rsp_data, mem_en, mem_addr, dbg_ptr, dbg_pending
  );

  modport master (
    output req_valid, req_addr, mem_data,
    input  req_ready, rsp_data, mem_en, mem_addr, dbg_ptr, dbg_pending
  );
endinterface

// File: rtl/memory_read_arbiter_rr.sv
// ---------------------------------------------------------------------------
// memory_read_arbiter_rr
//   Serves N = 2**PORT_ID_BITS engine-station read ports from one single-port
//   instruction BRAM. Each cycle one eligible port (requesting and with no
//   read in flight) is granted in round-robin order starting after the last
//   winner. The grant drives mem_en/mem_addr combinationally, and an owner
//   tag travels down a MEM_LATENCY-deep pipeline alongside the BRAM read.
//   When the tag leaves the pipeline the BRAM word is registered onto
//   rsp_data and the owners get a one-cycle req_ready pulse.
//
//   Ports
//     clk   clock
//     rst   synchronous, active-low reset
//     bus   memory_read_arbiter_rr_if.slave (requests, responses, BRAM,
//           debug view of the round-robin pointer and pending mask)
//
//   Parameters must match the ones the interface instance was built with.
//
//   Optional feature: define MEM_ARB_COALESCE_EN to let every other eligible
//   port asking for the winner's address ride on the same BRAM read. Without
//   it, equal addresses are served one port at a time.
// ---------------------------------------------------------------------------
module memory_read_arbiter_rr #(
  parameter int PORT_ID_BITS      = 2,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  memory_read_arbiter_rr_if.slave  bus
);
  localparam int N  = 1 << PORT_ID_BITS;
  localparam int AW = MEMORY_ADDR_WIDTH;

  // Arbiter state
  logic [PORT_ID_BITS-1:0] ptr;       // last winner; search starts at ptr+1
  logic [N-1:0]            pending;   // port has a read in flight

  // Grant decision (combinational)
  logic [N-1:0]            eligible;
  logic                    grant;
  logic [PORT_ID_BITS-1:0] winner;
  logic [PORT_ID_BITS-1:0] idx;
  logic [AW-1:0]           winner_addr;
  logic [N-1:0]            owner;

  // Tag pipeline aligned with the BRAM read latency
  logic                    tag_valid [MEM_LATENCY];
  logic [N-1:0]            tag_owner [MEM_LATENCY];

  // Response registers
  logic [N-1:0]            req_ready_q;
  logic [MEMORY_WIDTH-1:0] rsp_data_q;

  // Nothing is granted while reset is asserted, so mem_en stays low and no
  // new tag is created during reset.
  always_comb begin
    eligible = '0;
    if (rst) begin
      eligible = bus.req_valid & ~pending;
    end
  end

  // Round-robin search: ptr+1, ptr+2, ... wrapping modulo N. The last step
  // (k == N) revisits ptr itself, so a lone requester can win repeatedly.
  always_comb begin
    grant  = 1'b0;
    winner = ptr;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ptr + PORT_ID_BITS'(k);
      if (!grant && eligible[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    winner_addr = bus.req_addr[int'(winner)*AW +: AW];
  end

  // Owner mask: who receives the response of this grant.
  always_comb begin
    owner = '0;
    if (grant) begin
      owner[winner] = 1'b1;
`ifdef MEM_ARB_COALESCE_EN
      for (int i = 0; i < N; i++) begin
        if (eligible[i] && (bus.req_addr[i*AW +: AW] == winner_addr)) begin
          owner[i] = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr         <= PORT_ID_BITS'(N - 1);
      pending     <= '0;
      req_ready_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_owner[i] <= '0;
      end
    end else begin
      if (grant) begin
        ptr <= winner;
      end

      // A port's pending bit drops the cycle after its ready pulse. The
      // set and clear terms never hit the same port: a pending port is not
      // eligible, so it cannot be an owner.
      pending <= (pending & ~req_ready_q) | owner;

      tag_valid[0] <= grant;
      tag_owner[0] <= owner;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end

      // rsp_data only moves when a tag completes, so it holds otherwise.
      if (tag_valid[MEM_LATENCY-1]) begin
        rsp_data_q  <= bus.mem_data;
        req_ready_q <= tag_owner[MEM_LATENCY-1];
      end else begin
        req_ready_q <= '0;
      end
    end
  end

  assign bus.mem_en      = grant;
  assign bus.mem_addr    = grant ? winner_addr : '0;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.dbg_ptr     = ptr;
  assign bus.dbg_pending = pending;

endmodule

// File: tb/tb_memory_read_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_memory_read_arbiter_rr
//   Two arbiters share one clock: dut1 with a 1-cycle BRAM, dut3 with a
//   3-cycle BRAM. Each has its own BRAM model, expected-response queue and
//   monitor. Directed stimulus pushes hand-computed {cycle, ready mask, data}
//   entries; the monitors pop and compare whenever req_ready is non-zero.
// ---------------------------------------------------------------------------
module tb_memory_read_arbiter_rr;
  localparam int PB = 2;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int EW = 36;   // {cycle[15:0], ready[3:0], data[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  memory_read_arbiter_rr_if #(.PORT_ID_BITS(PB), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) bus1 ();
  memory_read_arbiter_rr_if #(.PORT_ID_BITS(PB), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) bus3 ();

  memory_read_arbiter_rr #(
    .PORT_ID_BITS(PB), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(1)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  memory_read_arbiter_rr #(
    .PORT_ID_BITS(PB), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(3)
  ) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  // ---------------- BRAM models ----------------
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1 <= bus1.mem_en ? mem[bus1.mem_addr] : '0;
  end
  assign bus1.mem_data = pipe1;

  always @(posedge clk) begin
    pipe3[0] <= bus3.mem_en ? mem[bus3.mem_addr] : '0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign bus3.mem_data = pipe3[2];

  int en_cnt1 = 0;
  always @(posedge clk) begin
    if (bus1.mem_en) en_cnt1 <= en_cnt1 + 1;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect1(input int cy, input logic [3:0] m, input logic [DW-1:0] d);
    exp_q1.push_back({16'(cy), m, d});
  endtask

  task automatic expect3(input int cy, input logic [3:0] m, input logic [DW-1:0] d);
    exp_q3.push_back({16'(cy), m, d});
  endtask

  always @(negedge clk) begin
    if (bus1.req_ready !== '0) begin
      if (exp_q1.size() == 0) check("rsp1_unexpected", 64'({cyc[15:0], bus1.req_ready, bus1.rsp_data}), 64'(0));
      else check("rsp1", 64'({cyc[15:0], bus1.req_ready, bus1.rsp_data}), 64'(exp_q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus3.req_ready !== '0) begin
      if (exp_q3.size() == 0) check("rsp3_unexpected", 64'({cyc[15:0], bus3.req_ready, bus3.rsp_data}), 64'(0));
      else check("rsp3", 64'({cyc[15:0], bus3.req_ready, bus3.rsp_data}), 64'(exp_q3.pop_front()));
    end
  end

  // ---------------- drivers ----------------
  logic auto_drop = 1'b1;   // release a request once its ready pulse is seen

  task automatic tick();
    @(negedge clk);
    if (auto_drop) begin
      bus1.req_valid = bus1.req_valid & ~bus1.req_ready;
      bus3.req_valid = bus3.req_valid & ~bus3.req_ready;
    end
  endtask

  task automatic req1(input int p, input logic [AW-1:0] a);
    bus1.req_addr[p*AW +: AW] = a;
    bus1.req_valid[p] = 1'b1;
  endtask

  task automatic req3(input int p, input logic [AW-1:0] a);
    bus3.req_addr[p*AW +: AW] = a;
    bus3.req_valid[p] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] fair_addr [4];
  logic [DW-1:0] fair_data [4];
  int c;
  int en_start;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 37 + 16'h1234);
    mem[11'h05a] = 16'hBEEF;
    mem[11'h100] = 16'hC0DE;
    mem[11'h010] = 16'h1010;
    mem[11'h020] = 16'h2020;
    mem[11'h077] = 16'h7777;
    fair_addr[0] = 11'h011; fair_data[0] = 16'hA011; mem[11'h011] = 16'hA011;
    fair_addr[1] = 11'h022; fair_data[1] = 16'hA022; mem[11'h022] = 16'hA022;
    fair_addr[2] = 11'h033; fair_data[2] = 16'hA033; mem[11'h033] = 16'hA033;
    fair_addr[3] = 11'h044; fair_data[3] = 16'hA044; mem[11'h044] = 16'hA044;

    rst1 = 1'b0;
    rst3 = 1'b0;
    bus1.req_valid = '0;
    bus1.req_addr  = '0;
    bus3.req_valid = '0;
    bus3.req_addr  = '0;

    // 1. Reset with every port requesting: nothing granted, nothing returned.
    for (int p = 0; p < N; p++) req1(p, fair_addr[p]);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rst_mem_en", 64'(bus1.mem_en), 64'(0));
      check("rst_req_ready", 64'(bus1.req_ready), 64'(0));
    end
    check("rst_rsp_data", 64'(bus1.rsp_data), 64'(0));
    check("rst_mem_addr", 64'(bus1.mem_addr), 64'(0));
    check("rst_pending", 64'(bus1.dbg_pending), 64'(0));
    check("rst_ptr", 64'(bus1.dbg_ptr), 64'(3));

    // 3. Fairness: all four held for 16 grants; order 0,1,2,3,...
    auto_drop = 1'b0;
    rst1 = 1'b1;
    c = cyc;
    #1;
    check("first_grant_en", 64'(bus1.mem_en), 64'(1));
    check("first_grant_addr", 64'(bus1.mem_addr), 64'(fair_addr[0]));
    for (int k = 0; k < 16; k++) expect1(c + k + 2, 4'(1 << (k % 4)), fair_data[k % 4]);
    for (int k = 1; k < 16; k++) begin
      tick();
      #1;
      check("fair_grant_en", 64'(bus1.mem_en), 64'(1));
      check("fair_grant_addr", 64'(bus1.mem_addr), 64'(fair_addr[k % 4]));
    end
    tick();
    bus1.req_valid = '0;
    auto_drop = 1'b1;
    #1;
    check("fair_stop_en", 64'(bus1.mem_en), 64'(0));
    repeat (4) tick();

    // 2. Single port 2 at 0x05a, latency 1: ready 4'b0100 two cycles later.
    tick();
    c = cyc;
    req1(2, 11'h05a);
    expect1(c + 2, 4'b0100, 16'hBEEF);
    #1;
    check("single_en", 64'(bus1.mem_en), 64'(1));
    check("single_addr", 64'(bus1.mem_addr), 64'(11'h05a));
    repeat (4) tick();

    // 5. Ports 0 and 2 both want 0x100 (ptr=2, so port 0 wins first).
    tick();
    c = cyc;
    en_start = en_cnt1;
    req1(0, 11'h100);
    req1(2, 11'h100);
`ifdef MEM_ARB_COALESCE_EN
    expect1(c + 2, 4'b0101, 16'hC0DE);
`else
    expect1(c + 2, 4'b0001, 16'hC0DE);
    expect1(c + 3, 4'b0100, 16'hC0DE);
`endif
    #1;
    check("coal_en", 64'(bus1.mem_en), 64'(1));
    check("coal_addr", 64'(bus1.mem_addr), 64'(11'h100));
    repeat (5) tick();
`ifdef MEM_ARB_COALESCE_EN
    check("coal_mem_en_count", 64'(en_cnt1 - en_start), 64'(1));
`else
    check("coal_mem_en_count", 64'(en_cnt1 - en_start), 64'(2));
`endif

    // 6. Reset one cycle after a grant: that read never returns.
    tick();
    req1(1, 11'h077);
    #1;
    check("midrst_grant_en", 64'(bus1.mem_en), 64'(1));
    check("midrst_grant_addr", 64'(bus1.mem_addr), 64'(11'h077));
    tick();
    rst1 = 1'b0;
    bus1.req_valid = '0;
    #1;
    check("midrst_en_low", 64'(bus1.mem_en), 64'(0));
    tick();
    tick();
    rst1 = 1'b1;
    #1;
    check("midrst_pending", 64'(bus1.dbg_pending), 64'(0));
    check("midrst_ptr", 64'(bus1.dbg_ptr), 64'(3));
    check("midrst_ready", 64'(bus1.req_ready), 64'(0));
    repeat (4) tick();

    // 4. Latency 3: ports 1 and 3 granted back to back, readies at +4 and +5.
    check("lat3_rst_ready", 64'(bus3.req_ready), 64'(0));
    check("lat3_rst_ptr", 64'(bus3.dbg_ptr), 64'(3));
    tick();
    rst3 = 1'b1;
    tick();
    c = cyc;
    req3(1, 11'h010);
    req3(3, 11'h020);
    expect3(c + 4, 4'b0010, 16'h1010);
    expect3(c + 5, 4'b1000, 16'h2020);
    #1;
    check("lat3_grant0_en", 64'(bus3.mem_en), 64'(1));
    check("lat3_grant0_addr", 64'(bus3.mem_addr), 64'(11'h010));
    tick();
    #1;
    check("lat3_grant1_en", 64'(bus3.mem_en), 64'(1));
    check("lat3_grant1_addr", 64'(bus3.mem_addr), 64'(11'h020));
    tick();
    #1;
    check("lat3_both_pending_en", 64'(bus3.mem_en), 64'(0));
    check("lat3_pending", 64'(bus3.dbg_pending), 64'(4'b1010));
    repeat (8) tick();

    check("q1_drained", 64'(exp_q1.size()), 64'(0));
    check("q3_drained", 64'(exp_q3.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
